xalu_nibble_seq: RTL



---
 rtl/xalu_nibble_seq_if.sv | 41 ++++
 rtl/xalu_nibble_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/xalu_nibble_seq_if.sv
// Request/response handshake bundle between a requester and xalu_nibble_seq.
// Carries rsp_ovf only when XALU_SEQ_OVF_EN is defined.
interface xalu_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_func;
  logic             req_com;
  logic             req_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_d;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_neg_zero;
`ifdef XALU_SEQ_OVF_EN
  logic             rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_func, req_com, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_carry, rsp_zero, rsp_neg_zero, rsp_ovf
  );
  modport slave (
    input  req_valid, req_a, req_b, req_func, req_com, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_carry, rsp_zero, rsp_neg_zero, rsp_ovf
  );
`else
  modport master (
    output req_valid, req_a, req_b, req_func, req_com, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_d, rsp_carry, rsp_zero, rsp_neg_zero
  );
  modport slave (
    input  req_valid, req_a, req_b, req_func, req_com, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_d, rsp_carry, rsp_zero, rsp_neg_zero
  );
`endif
endinterface

// File: rtl/xalu_nibble_seq.sv
// Drives a combinational 4-bit ALU slice one nibble per clock to build WIDTH-bit results.
// Optional overflow flag (rsp_ovf) for ADD is enabled by defining XALU_SEQ_OVF_EN.
module xalu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  xalu_nibble_seq_if.slave    bus,
  output logic [3:0]          slice_a,
  output logic [3:0]          slice_b,
  output logic [2:0]          slice_f,
  output logic                slice_com,
  output logic                slice_ci_right,
  output logic                slice_ci_left,
  input  logic [3:0]          slice_d,
  input  logic                slice_co_left,
  input  logic                slice_co_right,
  input  logic                slice_zero,
  input  logic                slice_neg_zero
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef enum logic [2:0] {
    F_ADD, F_AND, F_OR, F_XOR, F_PASSA, F_PASSB, F_SHR, F_SHL
  } func_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  func_e            func_q, func_d;
  logic             com_q, com_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;

  logic             req_ready;
  logic             rsp_valid;
  logic [IW-1:0]    nib;

  // SHR walks MSB nibble first so the shift-in bit ripples downward.
  assign nib = (func_q == F_SHR) ? (LAST_IDX - idx_q) : idx_q;

  // NOTE: every combinational output and next-state gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    func_d         = func_q;
    com_d          = com_q;
    idx_d          = idx_q;
    carry_d        = carry_q;
    res_d          = res_q;
    zero_d         = zero_q;
    neg_d          = neg_q;
    ovf_d          = ovf_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    slice_a        = 4'h0;
    slice_b        = 4'h0;
    slice_f        = 3'h0;
    slice_com      = 1'b0;
    slice_ci_right = 1'b0;
    slice_ci_left  = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          func_d  = func_e'(bus.req_func);
          com_d   = bus.req_com;
          carry_d = bus.req_cin;
          idx_d   = '0;
          zero_d  = 1'b1;
          neg_d   = 1'b1;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        slice_a   = a_q[4*nib +: 4];
        slice_b   = b_q[4*nib +: 4];
        slice_f   = func_q;
        slice_com = com_q;

        // carry_q holds cin for the first nibble, then the previous nibble's carry-out.
        unique case (func_q)
          F_ADD, F_SHL: begin
            slice_ci_right = carry_q;
            carry_d        = slice_co_left;
          end
          F_SHR: begin
            slice_ci_left = carry_q;
            carry_d       = slice_co_right;
          end
          default: carry_d = 1'b0;
        endcase

        res_d[4*nib +: 4] = slice_d;
        zero_d            = zero_q & slice_zero;
        neg_d             = neg_q & slice_neg_zero;

        if (idx_q == LAST_IDX) begin
          if (func_q == F_ADD) begin
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    ((slice_d[3] ^ com_q) != a_q[WIDTH-1]);
          end
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= F_ADD;
      com_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      com_q   <= com_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_d        = res_q;
  assign bus.rsp_carry    = carry_q;
  assign bus.rsp_zero     = zero_q;
  assign bus.rsp_neg_zero = neg_q;
`ifdef XALU_SEQ_OVF_EN
  assign bus.rsp_ovf      = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
